// File: rtl/wb_unit.sv
// Write-back stage for an RV64 pipeline. Arbitrates between the ALU and the
// load/store unit, aligns and extends load data, registers the register file
// write port, and keeps a busy scoreboard of destinations with pending writes.
module wb_unit #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    // Issue-side scoreboard interface
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1_q,
    input  logic [4:0]      rs2_q,
    output logic            rs1_busy,
    output logic            rs2_busy,
    // ALU result
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    // Load result
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [1:0]      lsu_size,
    input  logic            lsu_unsigned,
    input  logic [2:0]      lsu_addr_lo,
    // Register file write port
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            err_misalign
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            ext;
    logic            misalign;

    logic            accept;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_data;
    logic            res_mis;

    logic            rf_wen_q;
    logic [4:0]      rf_rd_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic            err_q;
    logic            out_valid_q;

    logic [NREG-1:0] busy_q, busy_d;

    // LSU has fixed priority; the ALU waits whenever a load is present.
    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;

    // Align the load to bit 0 and sign/zero-extend from the top kept bit.
    always_comb begin
        shifted   = lsu_data >> {lsu_addr_lo, 3'b000};
        ext       = !lsu_unsigned;
        load_data = shifted;
        case (lsu_size)
            2'd0:    load_data = {{(XLEN-8){ext & shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = {{(XLEN-16){ext & shifted[15]}}, shifted[15:0]};
            2'd2:    load_data = {{(XLEN-32){ext & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Natural-alignment check for the current load.
    always_comb begin
        misalign = 1'b0;
        case (lsu_size)
            2'd1:    misalign = lsu_addr_lo[0];
            2'd2:    misalign = (lsu_addr_lo[1:0] != 2'd0);
            2'd3:    misalign = (lsu_addr_lo != 3'd0);
            default: misalign = 1'b0;
        endcase
    end

    // Select the accepted result for this cycle.
    always_comb begin
        accept   = lsu_valid | alu_valid;
        res_rd   = alu_rd;
        res_data = alu_data;
        res_mis  = 1'b0;
        if (lsu_valid) begin
            res_rd   = lsu_rd;
            res_data = load_data;
            res_mis  = misalign;
        end
    end

    // Output stage: load rd/wdata only on accept so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q    <= 1'b0;
            rf_rd_q     <= 5'd0;
            rf_wdata_q  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rf_wen_q    <= accept && !res_mis && (res_rd != 5'd0);
            err_q       <= accept && res_mis;
            out_valid_q <= accept;
            if (accept) begin
                rf_rd_q    <= res_rd;
                rf_wdata_q <= res_data;
            end
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_rd        = rf_rd_q;
    assign rf_wdata     = rf_wdata_q;
    assign err_misalign = err_q;

    // Scoreboard next state: clear at the end of an output cycle, then a new
    // allocation of the same register overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (out_valid_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1_q];
    assign rs2_busy = busy_q[rs2_q];

endmodule

// File: tb/tb_wb_unit.sv
// Directed testbench for wb_unit with hand-computed expected values.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd, rs1_q, rs2_q;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [2:0]  lsu_addr_lo;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic        err_misalign;

    int checks = 0;
    int errors = 0;

    wb_unit #(.XLEN(64), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .rs1_q        (rs1_q),
        .rs2_q        (rs2_q),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_addr_lo  (lsu_addr_lo),
        .rf_wen       (rf_wen),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hDEAD;
        iss_valid = 1'b1; iss_rd = 5'd3; rs1_q = 5'd3; rs2_q = 5'd3;
        lsu_valid = 1'b1;
        #1;
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_alu_ready_lsu: got %0b want 0", alu_ready);
        end
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++; $display("FAIL reset_alu_ready_idle: got %0b want 1", alu_ready);
        end
        tick(); tick();
        rst = 1'b0; alu_valid = 1'b0; iss_valid = 1'b0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || err_misalign !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: wen=%0b err=%0b want 0 0", rf_wen, err_misalign);
        end
        checks++;
        if (rf_rd !== 5'd0 || rf_wdata !== 64'd0) begin
            errors++; $display("FAIL reset_regs: rd=%0d wdata=%h want 0 0", rf_rd, rf_wdata);
        end
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b want 0", rs1_busy);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++; $display("FAIL reset_no_wen_after: got %0b want 0", rf_wen);
        end
    endtask

    task automatic test_alu_path();
        iss_valid = 1'b1; iss_rd = 5'd5; rs1_q = 5'd5; rs2_q = 5'd0;
        tick();                                   // cycle 1
        iss_valid = 1'b0;
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            errors++; $display("FAIL alu_busy_c1: got %0b want 1", rs1_busy);
        end
        tick();                                   // cycle 2
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || alu_ready !== 1'b1) begin
            errors++; $display("FAIL alu_c2: busy=%0b ready=%0b want 1 1", rs1_busy, alu_ready);
        end
        tick();                                   // cycle 3
        alu_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 64'h1234) begin
            errors++;
            $display("FAIL alu_write: wen=%0b rd=%0d wdata=%h want 1 5 1234", rf_wen, rf_rd, rf_wdata);
        end
        checks++;
        if (rs1_busy !== 1'b1) begin
            errors++; $display("FAIL alu_busy_c3: got %0b want 1", rs1_busy);
        end
        tick();                                   // cycle 4
        checks++;
        if (rs1_busy !== 1'b0 || rf_wen !== 1'b0) begin
            errors++; $display("FAIL alu_c4: busy=%0b wen=%0b want 0 0", rs1_busy, rf_wen);
        end
        checks++;
        if (rf_rd !== 5'd5 || rf_wdata !== 64'h1234) begin
            errors++; $display("FAIL alu_hold: rd=%0d wdata=%h want 5 1234", rf_rd, rf_wdata);
        end
    endtask

    task automatic test_load_extend();
        logic [63:0] data_v [5];
        logic [1:0]  size_v [5];
        logic        uns_v  [5];
        logic [2:0]  addr_v [5];
        logic [63:0] exp_v  [5];
        data_v[0] = 64'h80FF;                size_v[0] = 2'd0; uns_v[0] = 1'b0; addr_v[0] = 3'd1;
        exp_v[0]  = 64'hFFFF_FFFF_FFFF_FF80;
        data_v[1] = 64'h80FF;                size_v[1] = 2'd0; uns_v[1] = 1'b1; addr_v[1] = 3'd1;
        exp_v[1]  = 64'h80;
        data_v[2] = 64'h80FF;                size_v[2] = 2'd1; uns_v[2] = 1'b0; addr_v[2] = 3'd0;
        exp_v[2]  = 64'hFFFF_FFFF_FFFF_80FF;
        data_v[3] = 64'h8000_0001_0000_0000; size_v[3] = 2'd2; uns_v[3] = 1'b0; addr_v[3] = 3'd4;
        exp_v[3]  = 64'hFFFF_FFFF_8000_0001;
        data_v[4] = 64'hF123_4567_89AB_CDEF; size_v[4] = 2'd3; uns_v[4] = 1'b0; addr_v[4] = 3'd0;
        exp_v[4]  = 64'hF123_4567_89AB_CDEF;
        for (int i = 0; i < 5; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = data_v[i];
            lsu_size = size_v[i]; lsu_unsigned = uns_v[i]; lsu_addr_lo = addr_v[i];
            tick();
            lsu_valid = 1'b0;
            checks++;
            if (rf_wen !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== exp_v[i] || err_misalign !== 1'b0) begin
                errors++;
                $display("FAIL load_ext[%0d]: wen=%0b rd=%0d wdata=%h want 1 10 %h", i, rf_wen,
                         rf_rd, rf_wdata, exp_v[i]);
            end
        end
        tick();
    endtask

    task automatic test_conflict();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'hAAAA;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 64'h1122_3344_5566_7788;
        lsu_size = 2'd3; lsu_unsigned = 1'b0; lsu_addr_lo = 3'd0;
        #1;
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++; $display("FAIL conflict_ready: alu=%0b lsu=%0b want 0 1", alu_ready, lsu_ready);
        end
        tick();
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (rf_wen !== 1'b1 || rf_rd !== 5'd11 || rf_wdata !== 64'h1122_3344_5566_7788) begin
            errors++; $display("FAIL conflict_load_first: rd=%0d wdata=%h want 11 1122334455667788",
                               rf_rd, rf_wdata);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b1 || rf_rd !== 5'd6 || rf_wdata !== 64'hAAAA) begin
            errors++; $display("FAIL conflict_alu_second: wen=%0b rd=%0d wdata=%h want 1 6 aaaa",
                               rf_wen, rf_rd, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++; $display("FAIL conflict_idle: wen=%0b want 0", rf_wen);
        end
    endtask

    task automatic test_misalign();
        iss_valid = 1'b1; iss_rd = 5'd7; rs2_q = 5'd7;
        tick();
        iss_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h5555; lsu_size = 2'd2;
        lsu_unsigned = 1'b0; lsu_addr_lo = 3'd2;
        #1;
        checks++;
        if (rs2_busy !== 1'b1) begin
            errors++; $display("FAIL mis_busy_before: got %0b want 1", rs2_busy);
        end
        tick();
        lsu_valid = 1'b0;
        checks++;
        if (err_misalign !== 1'b1 || rf_wen !== 1'b0) begin
            errors++; $display("FAIL mis_pulse: err=%0b wen=%0b want 1 0", err_misalign, rf_wen);
        end
        tick();
        checks++;
        if (err_misalign !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++; $display("FAIL mis_after: err=%0b busy=%0b want 0 0", err_misalign, rs2_busy);
        end
    endtask

    task automatic test_x0_race();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h5;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1_q = 5'd0;
        tick();
        alu_valid = 1'b0; iss_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL x0: wen=%0b busy0=%0b want 0 0", rf_wen, rs1_busy);
        end
        iss_valid = 1'b1; iss_rd = 5'd9; rs1_q = 5'd9;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;           // re-allocate during the clearing cycle
        checks++;
        if (rf_wen !== 1'b1 || rf_rd !== 5'd9) begin
            errors++; $display("FAIL race_write: wen=%0b rd=%0d want 1 9", rf_wen, rf_rd);
        end
        tick();
        iss_valid = 1'b0;
        checks++;
        if (rs1_busy !== 1'b1) begin
            errors++; $display("FAIL race_set_wins: busy9=%0b want 1", rs1_busy);
        end
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL race_final_clear: busy9=%0b want 0", rs1_busy);
        end
    endtask

    task automatic test_mid_reset();
        iss_valid = 1'b1; iss_rd = 5'd12; rs1_q = 5'd12;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'h77;
        rst = 1'b1;
        tick();
        rst = 1'b0; alu_valid = 1'b0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || rf_wdata !== 64'd0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: wen=%0b wdata=%h busy=%0b want 0 0 0", rf_wen,
                               rf_wdata, rs1_busy);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++; $display("FAIL mid_reset_no_wen: wen=%0b want 0", rf_wen);
        end
    endtask

    initial begin
        rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; rs1_q = '0; rs2_q = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; lsu_size = '0;
        lsu_unsigned = 1'b0; lsu_addr_lo = '0;
        tick();
        test_reset();
        test_alu_path();
        test_load_extend();
        test_conflict();
        test_misalign();
        test_x0_race();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
# wb_unit

RV64 write-back stage that sits directly upstream of the 32×64 general-purpose register file. It arbitrates between the single-cycle ALU result and the load/store unit result, and aligns and sign/zero-extends load data. It drives the register file write port (wen/rd/wdata) from a registered output stage. A 32-entry busy scoreboard lets the issue stage stall on pending destination registers.

## Interface
Parameters:
- XLEN, 64, datapath width (only 64 supported)
- NREG, 32, architectural register count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- iss_valid  in  1  issue stage allocates destination iss_rd this cycle
- iss_rd  in  5  destination register being allocated
- rs1_q, rs2_q  in  5 each  source registers queried by issue
- rs1_busy, rs2_busy  out  1 each  queried register has a pending write
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination
- alu_data  in  64  ALU result
- lsu_valid  in  1  load data present
- lsu_ready  out  1  load accepted this cycle (always 1)
- lsu_rd  in  5  load destination
- lsu_data  in  64  raw 64-bit aligned memory word
- lsu_size  in  2  0=byte, 1=half, 2=word, 3=double
- lsu_unsigned  in  1  zero-extend when 1
- lsu_addr_lo  in  3  byte offset within the doubleword
- rf_wen  out  1  register file write enable (drives Control)
- rf_rd  out  5  write index (drives RD)
- rf_wdata  out  64  write data (drives RD_Back)
- err_misalign  out  1  one-cycle pulse on a misaligned load

## Operation
- Arbitration: LSU has fixed priority. lsu_ready=1 always; alu_ready = !lsu_valid. A held ALU result must stay stable until alu_ready=1.
- Load alignment: shift lsu_data right by lsu_addr_lo*8, keep the low 8/16/32/64 bits per lsu_size, then sign-extend from the top kept bit unless lsu_unsigned or size=3.
- Misaligned load, defined as (size=1 && addr_lo[0]) || (size=2 && addr_lo[1:0]!=0) || (size=3 && addr_lo!=0):
  - err_misalign pulses in the output cycle.
  - rf_wen is suppressed.
  - The busy bit is still cleared.
- Output register: on an accepted result, rf_rd and rf_wdata are loaded. rf_wen = accepted && !misaligned && rd!=0. With no accept, rf_wen=0; rf_rd and rf_wdata hold their previous values.
- Scoreboard, busy[31:0]:
  - Set on iss_valid when iss_rd!=0.
  - Cleared on the edge at which an output cycle (rf_wen or err_misalign, or rd!=0 commit) ends.
  - busy[0] is always 0.
  - Simultaneous set and clear of the same register: set wins (new producer).
- rs1_busy = busy[rs1_q] and rs2_busy = busy[rs2_q], combinational from registered state, with no bypass of same-cycle set/clear.
- Accepting a result for a register that is not busy is legal: it is written, and busy stays 0.

## Timing
- Reset (synchronous): rf_wen=0, rf_rd=0, rf_wdata=0, err_misalign=0, busy=0. Hence rs1_busy=rs2_busy=0. alu_ready follows lsu_valid combinationally.
- Reset asserted mid-operation discards any registered result and clears all busy bits on that edge; no rf_wen follows.
- Latency: result accepted in cycle N → rf_wen/rf_rd/rf_wdata valid in cycle N+1. The register file writes at the end of N+1; the busy bit clears at that same edge and reads 0 from N+2.
- Throughput: one write per cycle. Under continuous lsu_valid, the ALU stalls indefinitely (no fairness requirement).
- iss_valid in cycle N → busy visible from N+1.

## Test plan
- Reset: assert rst for 2 cycles with alu_valid=1 → rf_wen=0, all busy=0, err_misalign=0 after release.
- ALU path: iss rd=5 at cycle 0; ALU rd=5, data=0x1234 at cycle 2 → rs1_busy(5)=1 in cycles 1-3; rf_wen=1, rd=5, wdata=0x1234 in cycle 3; busy 0 at cycle 4.
- Load extend: data=0x00000000_0000_80FF, addr_lo=1, size=0, signed → wdata=0xFFFF_FFFF_FFFF_FF80. Same input with unsigned → 0x80. Half at addr_lo=0, signed → 0xFFFF_FFFF_FFFF_80FF.
- Conflict: alu_valid and lsu_valid both high in one cycle → alu_ready=0, load written first; ALU written the following cycle.
- Misaligned: size=2, addr_lo=2, rd=7 busy → err_misalign=1 for one cycle, rf_wen=0, busy[7] cleared.
- x0 and set/clear race: ALU rd=0 → rf_wen=0. Issue rd=9 in the same cycle as rd=9 is cleared → busy[9] remains 1.
